// File: rtl/banked_mem_resp.sv
// Four-bank interleaved word memory responder.
// Bank = addr[2:1], row = addr[BANK_AW+2:3]. Each bank accepts one access every
// BUSY_CYC cycles. Read data appears two cycles after acceptance.
module banked_mem_resp #(
    parameter int BANK_AW  = 13,
    parameter int BUSY_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);

    localparam int         DEPTH    = 1 << BANK_AW;
    localparam logic [2:0] CNT_LOAD = 3'(BUSY_CYC - 1);

    logic               req;
    logic               err_w;
    logic               stall_w;
    logic               acc;
    logic [1:0]         bank;
    logic [BANK_AW-1:0] row;

    // Per-bank read registers, gathered for the stage-1 select.
    logic [15:0] bank_rdata [4];

    // Read pipeline: stage 1 is the per-bank read register plus its bank select.
    logic        v_s1_q, v_s1_d;
    logic [1:0]  rsel_q, rsel_d;
    logic [15:0] data_out_q, data_out_d;
    logic        dv_q, dv_d;

    assign bank = addr[2:1];
    assign row  = addr[BANK_AW+2:3];

    // Request decode. Errors and stalls depend only on inputs and busy flags.
    assign req     = rd ^ wr;
    assign err_w   = (rd & wr) | ((rd | wr) & addr[0]);
    assign stall_w = req & ~err_w & busy[bank];
    assign acc     = req & ~err_w & ~stall_w;

    assign err        = err_w;
    assign stall      = stall_w;
    assign data_out   = data_out_q;
    assign data_valid = dv_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bank
            logic [15:0] mem_q [DEPTH];
            logic [15:0] rdata_q;
            logic [2:0]  cnt_q, cnt_d;
            logic        bank_acc;

            assign bank_acc       = acc && (bank == 2'(gi));
            assign busy[gi]       = (cnt_q != 3'd0);
            assign bank_rdata[gi] = rdata_q;

            // Occupancy counter: reload on accept, otherwise count down to idle.
            always_comb begin
                cnt_d = cnt_q;
                if (bank_acc) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            // Counter register; reset frees the bank immediately.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= 3'd0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // Block-RAM style array with registered read; contents survive reset.
            always_ff @(posedge clk) begin
                if (bank_acc) begin
                    if (wr) begin
                        mem_q[row] <= data_in;
                    end else begin
                        rdata_q <= mem_q[row];
                    end
                end
            end
        end
    endgenerate

    // Read pipeline next state; data_out holds its value when no result arrives.
    // The selected bank register cannot be overwritten before it is consumed,
    // since that bank stays busy for at least two cycles.
    always_comb begin
        v_s1_d     = acc & rd;
        rsel_d     = rsel_q;
        dv_d       = v_s1_q;
        data_out_d = data_out_q;
        if (acc && rd) begin
            rsel_d = bank;
        end
        if (v_s1_q) begin
            data_out_d = bank_rdata[rsel_q];
        end
    end

    // Read pipeline registers; reset cancels any read in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_s1_q     <= 1'b0;
            rsel_q     <= 2'd0;
            dv_q       <= 1'b0;
            data_out_q <= 16'h0000;
        end else begin
            v_s1_q     <= v_s1_d;
            rsel_q     <= rsel_d;
            dv_q       <= dv_d;
            data_out_q <= data_out_d;
        end
    end

endmodule

// File: doc/banked_mem_resp.md
# banked_mem_resp

Four-bank interleaved memory responder serving the direct-mapped cache controller's line fill and write-back traffic. Accepts one word read or write per cycle and returns read data a fixed two cycles after acceptance. Each bank stays busy for four cycles per access; requests to a busy bank are stalled. It sits below the cache FSM in `cache_direct`, and doubles as the memory model in cache-level benches.

## Interface
- `BANK_AW`, default 13: word-address bits per bank. Each bank holds 2^BANK_AW 16-bit words, covering byte addresses `addr[15:0]` when set to 13.
- `BUSY_CYC`, default 4: cycles a bank is occupied per accepted access, including the acceptance cycle. Legal range 2..7.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `addr`  in  16: byte address. Bank = `addr[2:1]`; row = `addr[BANK_AW+2:3]`; `addr[0]` must be 0.
- `data_in`  in  16: write data.
- `wr`  in  1: write request.
- `rd`  in  1: read request.
- `data_out`  out  16: read data, registered.
- `data_valid`  out  1: `data_out` holds the result of a read accepted two cycles earlier.
- `stall`  out  1: combinational; the current request was not accepted because its bank is busy.
- `busy`  out  4: registered per-bank busy flags; bit i corresponds to bank i.
- `err`  out  1: combinational; the current request is illegal and is ignored.

## Operation
- Request present: `req = rd ^ wr`.
- Error: `err = (rd & wr) | ((rd | wr) & addr[0])`. Any errored cycle changes no state. `stall` is 0 whenever `err` is 1.
- Bank conflict: `stall = req & ~err & busy[addr[2:1]]`. A stalled request is dropped. The initiator must re-present it; no request queueing.
- Accept: `acc = req & ~err & ~stall`.
- Per-bank down-counter `cnt[i]` (3 bits). On accept to bank i, load `BUSY_CYC-1`; otherwise decrement to 0. `busy[i] = (cnt[i] != 0)`.
- Write accept:
  - `data_in` is stored at the accept edge.
  - `data_valid` is not affected.
- Read accept:
  - The array word is captured into stage-1 register `rdata_s1` at the accept edge, with `v_s1 = 1`.
  - At the next edge, stage 1 moves to `data_out` / `data_valid`.
  - When `v_s1 = 0`, `data_valid` goes to 0 and `data_out` holds its last value.
- Read-after-write to the same address can only be accepted once the bank frees, and it returns the written data.
- Pipeline is two deep, with no backpressure. Back-to-back reads to banks 0, 1, 2, 3 on consecutive cycles give four consecutive `data_valid` cycles.

## Timing
- Reset (`rst` = 0, asynchronous):
  - `data_out` = 16'h0000, `data_valid` = 0, `v_s1` = 0, `busy` = 4'b0000, all `cnt` = 0.
  - Array contents are retained; they are not reset.
  - Reset asserted mid-read cancels the pending data; no `data_valid` follows after release.
- Read accepted in cycle t:
  - `data_valid` = 1 and `data_out` valid in cycle t+2, for exactly one cycle.
- Any access accepted to bank b in cycle t:
  - `busy[b]` = 1 in cycles t+1 .. t+BUSY_CYC-1.
  - A request to bank b stalls in those cycles and can first be accepted in cycle t+BUSY_CYC.
- Simultaneous events:
  - The accept edge of a new access to bank b coinciding with `cnt[b]` reaching 0 cannot happen, because a busy bank cannot accept.
  - A request to another bank is independent and is accepted the same cycle.
- `stall` and `err` depend only on the current inputs and registered `busy`. There is no path from `data_out`.

## Test plan
- Reset then write: release `rst`, write 16'hA5A5 @16'h0010 and 16'h1234 @16'h0012 in consecutive cycles → no stall; `busy` = 4'b0001 then 4'b0011.
- Read latency: after the banks free, read @16'h0010 in cycle t → `data_valid` = 1 and `data_out` = 16'hA5A5 in cycle t+2 only.
- Line fill: reads @0x0040/42/44/46 on four consecutive cycles → no stall; four consecutive `data_valid` cycles returning the stored words in order.
- Bank conflict: write @0x0008 (bank 0) in cycle t, then read @0x0000 held from t+1 → `stall` = 1 in t+1..t+3; accepted at t+4; data valid at t+6.
- Errors: `rd` = `wr` = 1 @0x0000 → `err` = 1, `stall` = 0, `busy` unchanged. `rd` @0x0001 → `err` = 1, no `data_valid` follows.
- Reset mid-op: read accepted in cycle t, `rst` low in t+1 → `data_valid` = 0 and `busy` = 0 immediately. After release, a re-read of the same address returns the pre-reset contents.
